// File: rtl/wallace_pkg.sv
// Shared types and widths for the 5x5 Wallace multiplier datapath.
package wallace_pkg;

  localparam int unsigned IN_W  = 5;
  localparam int unsigned OUT_W = 2 * IN_W;

  typedef logic [IN_W-1:0]  operand_t;
  typedef logic [OUT_W-1:0] row_t;

  typedef struct packed {
    row_t s;
    row_t c;
  } csa_rows_t;

  // One partial-product row: a gated by a single multiplier bit, placed at its weight.
  function automatic row_t pp_row(operand_t a, logic b_bit, int sh);
    return row_t'(a & {IN_W{b_bit}}) << sh;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise full-adder row: compresses three rows into a sum row and a pre-shifted carry row.
module csa_3to2 #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] maj;

  // Per-column full adder; carry moves up one weight, bit 0 of c is always 0.
  always_comb begin
    maj = (x & y) | (x & z) | (y & z);
    s   = x ^ y ^ z;
    c   = maj << 1;
  end

endmodule

// File: rtl/wallace_reduce_pipe.sv
// Partial-product generation and carry-save reduction of a 5x5 unsigned multiply down to
// two 10-bit rows, behind a valid/ready register stage.
// Optional macro WALLACE_PIPE_MID_EN adds a register between layer 2 and the final layer.
module wallace_reduce_pipe
  import wallace_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] sum_row,
  output logic [OUT_W-1:0] carry_row
);

  row_t      pp [IN_W];
  row_t      l1_s, l1_c, l2_s, l2_c;
  row_t      fin_s, fin_c, fin_x;
  csa_rows_t fin_rows;
  logic      fin_valid;

  logic      out_valid_q, out_valid_d, out_take, out_load;
  row_t      sum_q, sum_d, carry_q, carry_d;

  // Partial-product rows, row i carries in_b[i] at weight i.
  always_comb begin
    for (int i = 0; i < int'(IN_W); i++) begin
      pp[i] = pp_row(in_a, in_b[i], i);
    end
  end

  csa_3to2 #(.W(OUT_W)) u_csa_l1 (
    .x(pp[0]), .y(pp[1]), .z(pp[2]), .s(l1_s), .c(l1_c)
  );

  csa_3to2 #(.W(OUT_W)) u_csa_l2 (
    .x(l1_s), .y(l1_c), .z(pp[3]), .s(l2_s), .c(l2_c)
  );

  assign out_take = !out_valid_q || out_ready;

`ifdef WALLACE_PIPE_MID_EN
  logic      mid_valid_q, mid_valid_d, mid_take, mid_load;
  csa_rows_t mid_rows_q, mid_rows_d;
  row_t      mid_x_q, mid_x_d;

  // Mid stage accepts when empty or when its contents move into the output stage.
  always_comb begin
    mid_take    = !mid_valid_q || out_take;
    in_ready    = !rst && mid_take;
    mid_load    = in_valid && in_ready;
    mid_valid_d = mid_take ? mid_load : mid_valid_q;
    mid_rows_d  = mid_rows_q;
    mid_x_d     = mid_x_q;
    if (mid_load) begin
      mid_rows_d = '{s: l2_s, c: l2_c};
      mid_x_d    = pp[IN_W-1];
    end
    fin_valid = mid_valid_q;
    fin_rows  = mid_rows_q;
    fin_x     = mid_x_q;
  end

  // Mid stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_valid_q <= 1'b0;
      mid_rows_q  <= '0;
      mid_x_q     <= '0;
    end else begin
      mid_valid_q <= mid_valid_d;
      mid_rows_q  <= mid_rows_d;
      mid_x_q     <= mid_x_d;
    end
  end
`else
  // Final layer fed straight from layer 2; the input is gated only by the output stage.
  always_comb begin
    in_ready  = !rst && out_take;
    fin_valid = in_valid && in_ready;
    fin_rows  = '{s: l2_s, c: l2_c};
    fin_x     = pp[IN_W-1];
  end
`endif

  csa_3to2 #(.W(OUT_W)) u_csa_fin (
    .x(fin_rows.s), .y(fin_rows.c), .z(fin_x), .s(fin_s), .c(fin_c)
  );

  // Output stage: load when empty or draining, otherwise hold everything bit-stable.
  always_comb begin
    out_load    = fin_valid && out_take;
    out_valid_d = out_take ? fin_valid : out_valid_q;
    sum_d       = out_load ? fin_s : sum_q;
    carry_d     = out_load ? fin_c : carry_q;
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_row   = sum_q;
  assign carry_row = carry_q;

endmodule
